// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR frame controller: FSM state encoding and
// the Galois LFSR step function used by the LFSR register.
package lfsr_pkg;

    // Widest LFSR the step function supports; callers zero-extend into it.
    localparam int LFSR_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Galois step: shift right, fold the polynomial in when the bit shifted
    // out was 1. Zero-extended upper bits stay zero, so callers can truncate.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (state >> 1) ^ (state[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: tdata/tvalid/tlast from master, tready back.
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lfsr_step_reg.sv
// LFSR register: load (with zero-seed substitution) takes priority over step.
module lfsr_step_reg
    import lfsr_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [DATA_WIDTH-1:0] poly_i,
    output logic [DATA_WIDTH-1:0] lfsr_o
);

    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] load_val;

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign load_val = (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;

    // State register: reload on load, advance one Galois step on step.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_q <= '0;
        end else if (load_i) begin
            lfsr_q <= load_val;
        end else if (step_i) begin
            lfsr_q <= DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(poly_i)));
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/lfsr_frame_ctrl.sv
// LFSR frame generator: emits framed pseudo-random beats on an AXI-Stream
// master with optional idle gaps, a frame limit (0 = continuous) and a
// graceful stop that always finishes the current frame.
module lfsr_frame_ctrl
    import lfsr_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int LEN_WIDTH        = 16,
    parameter bit RESEED_PER_FRAME = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [DATA_WIDTH-1:0] poly_i,
    input  logic [LEN_WIDTH-1:0] frame_len_i,
    input  logic [LEN_WIDTH-1:0] gap_len_i,
    input  logic [LEN_WIDTH-1:0] num_frames_i,
    axis_if.master               m_axis,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_WIDTH-1:0] frame_cnt_o,
    output state_t               state_o
);

    // Handshake: a beat transfers on a rising clk_i edge where tvalid and
    // tready are both 1. tvalid is high only in SEND; once raised, tdata,
    // tlast and tvalid stay unchanged until the transfer happens, because
    // the LFSR and beat counter only move on a transfer.

    state_t state_q, state_d;

    // Latched run configuration
    logic [DATA_WIDTH-1:0] seed_q, poly_q;
    logic [LEN_WIDTH-1:0]  frame_len_q, gap_len_q, num_frames_q;

    // Run counters and stop flag
    logic [LEN_WIDTH-1:0]  beat_q, gap_cnt_q, frame_cnt_q;
    logic                  stop_pend_q;

    // FSM control strobes
    logic latch_cfg, lfsr_load, lfsr_step;
    logic beat_clr, beat_inc, gap_clr, gap_inc, cnt_clr, cnt_inc;
    logic tvalid, done;

    logic [DATA_WIDTH-1:0] lfsr;
    logic [LEN_WIDTH-1:0]  last_beat, gap_last, cnt_plus;
    logic                  handshake, is_last, limit_hit, stop_seen;

    // frame_len 0 behaves like 1: every beat is the last one.
    assign last_beat = (frame_len_q == '0) ? '0 : frame_len_q - LEN_WIDTH'(1);
    assign gap_last  = gap_len_q - LEN_WIDTH'(1);
    assign cnt_plus  = frame_cnt_q + LEN_WIDTH'(1);
    assign handshake = tvalid && m_axis.tready;
    assign is_last   = (beat_q == last_beat);
    // Continuous mode (0) never hits the limit, so the counter may wrap.
    assign limit_hit = (num_frames_q != '0) && (cnt_plus == num_frames_q);
    // A stop arriving this cycle counts as well as one already registered.
    assign stop_seen = stop_pend_q || stop_i;

    lfsr_step_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .seed_i (seed_q),
        .poly_i (poly_q),
        .lfsr_o (lfsr)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        beat_clr  = 1'b0;
        beat_inc  = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        tvalid    = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                // start wins over stop; stop alone does nothing here
                if (start_i) begin
                    latch_cfg = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                lfsr_load = 1'b1;
                beat_clr  = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                tvalid = 1'b1;
                if (handshake) begin
                    if (is_last) begin
                        cnt_inc  = 1'b1;
                        beat_clr = 1'b1;
                        gap_clr  = 1'b1;
                        if (limit_hit || stop_seen) begin
                            lfsr_step = 1'b1;
                            state_d   = DONE;
                        end else if (gap_len_q != '0) begin
                            lfsr_step = 1'b1;
                            state_d   = GAP;
                        end else begin
                            // back-to-back: the next frame starts right away
                            lfsr_load = RESEED_PER_FRAME;
                            lfsr_step = !RESEED_PER_FRAME;
                            state_d   = SEND;
                        end
                    end else begin
                        beat_inc  = 1'b1;
                        lfsr_step = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop_seen) begin
                    state_d = DONE;
                end else if (gap_cnt_q == gap_last) begin
                    lfsr_load = RESEED_PER_FRAME;
                    state_d   = SEND;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration latch, counters and sticky stop flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            seed_q       <= '0;
            poly_q       <= '0;
            frame_len_q  <= '0;
            gap_len_q    <= '0;
            num_frames_q <= '0;
            beat_q       <= '0;
            gap_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            stop_pend_q  <= 1'b0;
        end else begin
            if (latch_cfg) begin
                seed_q       <= seed_i;
                poly_q       <= poly_i;
                frame_len_q  <= frame_len_i;
                gap_len_q    <= gap_len_i;
                num_frames_q <= num_frames_i;
            end
            if (beat_clr) begin
                beat_q <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + LEN_WIDTH'(1);
            end
            if (gap_clr) begin
                gap_cnt_q <= '0;
            end else if (gap_inc) begin
                gap_cnt_q <= gap_cnt_q + LEN_WIDTH'(1);
            end
            if (cnt_clr) begin
                frame_cnt_q <= '0;
            end else if (cnt_inc) begin
                frame_cnt_q <= cnt_plus;
            end
            if (latch_cfg) begin
                stop_pend_q <= 1'b0;
            end else if ((state_q != IDLE) && stop_i) begin
                stop_pend_q <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = lfsr;
    assign m_axis.tlast  = tvalid && is_last;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done;
    assign frame_cnt_o   = frame_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_lfsr_frame_ctrl.sv
// Directed bench for lfsr_frame_ctrl (8-bit LFSR, poly 0xB8). Two instances
// share all inputs: dut_a continues the sequence across frames, dut_b
// reseeds at every frame start.
module tb_lfsr_frame_ctrl;
    import lfsr_pkg::*;

    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [DW-1:0] seed_i = '0;
    logic [DW-1:0] poly_i = '0;
    logic [LW-1:0] frame_len_i = '0;
    logic [LW-1:0] gap_len_i = '0;
    logic [LW-1:0] num_frames_i = '0;
    logic          tready = 1'b1;

    logic          busy_a, done_a, busy_b, done_b;
    logic [LW-1:0] frame_cnt_a, frame_cnt_b;
    state_t        state_a, state_b;

    axis_if #(.DATA_WIDTH(DW)) axis_a ();
    axis_if #(.DATA_WIDTH(DW)) axis_b ();
    assign axis_a.tready = tready;
    assign axis_b.tready = tready;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_seq [0:11];

    lfsr_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .RESEED_PER_FRAME(1'b0)) dut_a (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
        .seed_i(seed_i), .poly_i(poly_i), .frame_len_i(frame_len_i),
        .gap_len_i(gap_len_i), .num_frames_i(num_frames_i), .m_axis(axis_a),
        .busy_o(busy_a), .done_o(done_a), .frame_cnt_o(frame_cnt_a), .state_o(state_a)
    );

    lfsr_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .RESEED_PER_FRAME(1'b1)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
        .seed_i(seed_i), .poly_i(poly_i), .frame_len_i(frame_len_i),
        .gap_len_i(gap_len_i), .num_frames_i(num_frames_i), .m_axis(axis_b),
        .busy_o(busy_b), .done_o(done_b), .frame_cnt_o(frame_cnt_b), .state_o(state_b)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input logic [DW-1:0] seed, input logic [LW-1:0] flen,
                             input logic [LW-1:0] glen, input logic [LW-1:0] nfr);
        seed_i       = seed;
        poly_i       = 8'hB8;
        frame_len_i  = flen;
        gap_len_i    = glen;
        num_frames_i = nfr;
    endtask

    initial begin
        int hs;
        int cyc;
        exp_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3,
                    8'hE1, 8'hC8, 8'h64, 8'h32, 8'h19, 8'hB4};

        // Reset state
        #2;
        check("rst_tvalid", 32'(axis_a.tvalid), 32'd0);
        check("rst_tlast", 32'(axis_a.tlast), 32'd0);
        check("rst_tdata", 32'(axis_a.tdata), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
        check("rst_state", 32'(state_a), 32'(IDLE));
        #10;
        rstn_i = 1'b1;
        tick();

        // Basic single frame, tready always 1
        configure(8'h01, 16'd6, 16'd0, 16'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("basic_load_state", 32'(state_a), 32'(LOAD));
        check("basic_load_busy", 32'(busy_a), 32'd1);
        check("basic_load_tvalid", 32'(axis_a.tvalid), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("basic_tvalid", 32'(axis_a.tvalid), 32'd1);
            check("basic_tdata", 32'(axis_a.tdata), 32'(exp_seq[i]));
            check("basic_tlast", 32'(axis_a.tlast), 32'(i == 5));
            tick();
        end
        check("basic_done", 32'(done_a), 32'd1);
        check("basic_done_tvalid", 32'(axis_a.tvalid), 32'd0);
        check("basic_frame_cnt", 32'(frame_cnt_a), 32'd1);
        tick();
        check("basic_done_drop", 32'(done_a), 32'd0);
        check("basic_idle_busy", 32'(busy_a), 32'd0);
        check("basic_cnt_hold", 32'(frame_cnt_a), 32'd1);

        // Backpressure: tready pattern 1,0,0 repeating
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        hs = 0;
        cyc = 0;
        while (hs < 6 && cyc < 60) begin
            tready = (cyc % 3 == 0);
            check("bp_tvalid", 32'(axis_a.tvalid), 32'd1);
            check("bp_tdata", 32'(axis_a.tdata), 32'(exp_seq[hs]));
            check("bp_tlast", 32'(axis_a.tlast), 32'(hs == 5));
            if (tready) hs++;
            tick();
            cyc++;
        end
        tready = 1'b1;
        check("bp_handshakes", 32'(hs), 32'd6);
        check("bp_done", 32'(done_a), 32'd1);
        check("bp_frame_cnt", 32'(frame_cnt_a), 32'd1);
        tick();

        // Gap of 3 cycles between two frames of 2 beats
        configure(8'h01, 16'd2, 16'd3, 16'd2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("gap_f1b0_a", 32'(axis_a.tdata), 32'h01);
        check("gap_f1b0_b", 32'(axis_b.tdata), 32'h01);
        check("gap_f1b0_tlast", 32'(axis_b.tlast), 32'd0);
        tick();
        check("gap_f1b1_a", 32'(axis_a.tdata), 32'hB8);
        check("gap_f1b1_b", 32'(axis_b.tdata), 32'hB8);
        check("gap_f1b1_tlast", 32'(axis_b.tlast), 32'd1);
        tick();
        for (int g = 0; g < 3; g++) begin
            check("gap_idle_tvalid_a", 32'(axis_a.tvalid), 32'd0);
            check("gap_idle_tvalid_b", 32'(axis_b.tvalid), 32'd0);
            check("gap_idle_busy", 32'(busy_b), 32'd1);
            check("gap_idle_cnt", 32'(frame_cnt_b), 32'd1);
            tick();
        end
        check("gap_f2b0_tvalid", 32'(axis_b.tvalid), 32'd1);
        check("gap_f2b0_a", 32'(axis_a.tdata), 32'h5C);
        check("gap_f2b0_b", 32'(axis_b.tdata), 32'h01);
        tick();
        check("gap_f2b1_a", 32'(axis_a.tdata), 32'h2E);
        check("gap_f2b1_b", 32'(axis_b.tdata), 32'hB8);
        check("gap_f2b1_tlast", 32'(axis_b.tlast), 32'd1);
        tick();
        check("gap_done_b", 32'(done_b), 32'd1);
        check("gap_cnt_a", 32'(frame_cnt_a), 32'd2);
        check("gap_cnt_b", 32'(frame_cnt_b), 32'd2);
        tick();

        // Continuous, back-to-back frames of 4; stop on beat 2 of frame 3;
        // a stray start mid-run must be ignored
        configure(8'h01, 16'd4, 16'd0, 16'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) begin
            stop_i  = (k == 9);
            start_i = (k == 5);
            check("cont_tvalid", 32'(axis_a.tvalid), 32'd1);
            check("cont_tdata_a", 32'(axis_a.tdata), 32'(exp_seq[k]));
            check("cont_tdata_b", 32'(axis_b.tdata), 32'(exp_seq[k % 4]));
            check("cont_tlast", 32'(axis_a.tlast), 32'((k % 4) == 3));
            check("cont_frame_cnt", 32'(frame_cnt_a), 32'(k / 4));
            tick();
        end
        stop_i  = 1'b0;
        start_i = 1'b0;
        check("stop_done_a", 32'(done_a), 32'd1);
        check("stop_done_b", 32'(done_b), 32'd1);
        check("stop_tvalid", 32'(axis_a.tvalid), 32'd0);
        check("stop_cnt_a", 32'(frame_cnt_a), 32'd3);
        check("stop_cnt_b", 32'(frame_cnt_b), 32'd3);
        tick();
        check("stop_idle_busy", 32'(busy_a), 32'd0);
        check("stop_cnt_hold", 32'(frame_cnt_a), 32'd3);

        // stop in IDLE is a no-op
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("idle_stop_busy", 32'(busy_a), 32'd0);
        check("idle_stop_state", 32'(state_a), 32'(IDLE));

        // start and stop together: start wins, run is not stopped
        configure(8'h00, 16'd4, 16'd0, 16'd0);
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("both_state", 32'(state_a), 32'(LOAD));
        tick();
        for (int k = 0; k < 5; k++) begin
            check("seed0_tvalid", 32'(axis_a.tvalid), 32'd1);
            check("seed0_tdata", 32'(axis_a.tdata), 32'(exp_seq[k]));
            tick();
        end
        check("seed0_cnt", 32'(frame_cnt_a), 32'd1);

        // Asynchronous reset between clock edges in the middle of a frame
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_tvalid", 32'(axis_a.tvalid), 32'd0);
        check("arst_tlast", 32'(axis_a.tlast), 32'd0);
        check("arst_tdata", 32'(axis_a.tdata), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_cnt", 32'(frame_cnt_a), 32'd0);
        #3;
        rstn_i = 1'b1;
        tick();
        check("arst_after_busy", 32'(busy_a), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("restart_tvalid", 32'(axis_a.tvalid), 32'd1);
        check("restart_tdata", 32'(axis_a.tdata), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_frame_ctrl.md
LFSR_FRAME_CTRL -- requirements
Module: lfsr_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, which sets the LFSR state and tdata width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, which sets the width of the frame-length, gap and frame-count fields.
REQ-003 SHALL have parameter RESEED_PER_FRAME, default 0; when 1, the LFSR reloads the seed at the start of every frame.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle start pulse.
REQ-007 SHALL have port stop_i, input, 1 bit: graceful-stop request.
REQ-008 SHALL have port seed_i, input, DATA_WIDTH: LFSR seed.
REQ-009 SHALL have port poly_i, input, DATA_WIDTH: Galois polynomial mask.
REQ-010 SHALL have port frame_len_i, input, LEN_WIDTH: beats per frame.
REQ-011 SHALL have port gap_len_i, input, LEN_WIDTH: idle cycles between frames.
REQ-012 SHALL have port num_frames_i, input, LEN_WIDTH: number of frames; 0 means continuous.
REQ-013 SHALL have port m_axis, axis_if.master, DATA_WIDTH: the output stream (tdata, tvalid, tlast; tready is an input).
REQ-014 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done_o, output, 1 bit: single-cycle pulse at the end of a run.
REQ-016 SHALL have port frame_cnt_o, output, LEN_WIDTH: number of frames completed in the current run.

Function
REQ-017 SHALL use FSM states IDLE, LOAD, SEND, GAP and DONE.
REQ-018 SHALL, in IDLE on start_i=1, latch seed, poly, frame_len, gap_len and num_frames, then go to LOAD; start_i outside IDLE SHALL be ignored.
REQ-019 SHALL, in LOAD (one cycle), set lfsr to the latched seed (seed 0 is replaced by 1), clear the beat counter, then go to SEND.
REQ-020 SHALL drive tvalid=1 in SEND only, with tdata=lfsr and tlast=1 when beat==frame_len-1 (frame_len 0 is treated as 1).
REQ-021 SHALL advance lfsr and beat only on handshake (tvalid&tready), using lfsr_next = (lfsr>>1) ^ (lfsr[0] ? poly : 0).
REQ-022 SHALL hold tdata, tlast and tvalid stable while tready=0.
REQ-023 SHALL, on the tlast handshake, increment frame_cnt; the next state is then DONE if the frame limit is reached or a stop is pending, otherwise GAP if gap_len>0, otherwise SEND back-to-back with no bubble.
REQ-024 SHALL, on entering a new frame with RESEED_PER_FRAME=1, reload lfsr from the latched seed; otherwise the sequence continues across frames.
REQ-025 SHALL, in GAP, hold tvalid=0 for exactly gap_len cycles, then enter SEND.
REQ-026 SHALL register stop_i as a sticky pending flag; the current frame always completes with tlast, and a stop seen during GAP goes straight to DONE.
REQ-027 SHALL, in DONE, pulse done_o for one cycle and return to IDLE; frame_cnt_o holds its value until the next start.
REQ-028 SHALL let the frame counter wrap modulo 2^LEN_WIDTH in continuous mode without terminating the run.
REQ-029 SHALL treat stop_i=1 in IDLE as a no-op.
REQ-030 SHALL give start_i priority over stop_i when both are asserted in IDLE.

Reset
REQ-031 SHALL, on rstn_i=0 asynchronously, force the state to IDLE, tvalid=0, tlast=0, tdata=0, busy_o=0, done_o=0, frame_cnt_o=0, lfsr=0 and all counters and latched configuration to 0.
REQ-032 SHALL, on reset mid-frame, drop tvalid immediately, without any tlast completion.

Structure
REQ-033 SHALL place the FSM state enum and the lfsr_next function in a shared package, lfsr_pkg.
REQ-034 SHALL use one natural sub-module, lfsr_step_reg: the LFSR register with load, step and seed-zero substitution.

Verification
REQ-035 SHALL cover basic sequence: DATA_WIDTH=8, poly=0xB8, seed=0x01, frame_len=6, num_frames=1, tready=1 -> tdata 01,B8,5C,2E,17,B3, tlast on B3, then done_o one cycle later.
REQ-036 SHALL cover backpressure: same configuration with tready toggling 1,0,0,1,... -> identical data order, tdata stable during stalls, exactly 6 handshakes.
REQ-037 SHALL cover gap and reseed: frame_len=2, gap_len=3, num_frames=2, RESEED_PER_FRAME=1 -> beats 01,B8, 3 idle cycles, 01,B8, frame_cnt_o=2.
REQ-038 SHALL cover stop in continuous mode: num_frames=0, frame_len=4, stop_i on beat 2 of frame 3 -> frame 3 completes with tlast, done_o pulses, frame_cnt_o=3.
REQ-039 SHALL cover async reset mid-frame: rstn_i low between clock edges -> tvalid=0 at once, busy_o=0, and a restart with seed 0x00 emits 01 first.
